// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to voice slots (retrigger, free, else LRU steal)
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  note_pressed,
  input  logic                  note_released,
  input  logic [6:0]            note,
  input  logic [6:0]            velocity,
  input  logic [3:0]            channel,
  output logic                  busy,
  output logic                  voice_we,
  output logic [VOICE_W-1:0]    voice_idx,
  output logic [6:0]            voice_note,
  output logic [6:0]            voice_vel,
  output logic                  voice_gate,
  output logic                  steal,
  output logic                  drop,
  output logic [NUM_VOICES-1:0] active_mask
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [VOICE_W-1:0] LAST = VOICE_W'(NUM_VOICES - 1);
  logic [1:0]            r_state;
  logic [VOICE_W-1:0]    r_cnt;
  logic [6:0]            r_note;
  logic [6:0]            r_vel;
  logic [3:0]            r_ch;
  logic                  r_on;
  logic [NUM_VOICES-1:0] r_active;
  logic [6:0]            r_snote [NUM_VOICES];
  logic [3:0]            r_sch   [NUM_VOICES];
  logic [VOICE_W-1:0]    r_age   [NUM_VOICES];
  logic                  r_mv;
  logic                  r_fv;
  logic [VOICE_W-1:0]    r_midx;
  logic [VOICE_W-1:0]    r_fidx;
  logic [VOICE_W-1:0]    r_oidx;
  logic                  w_ev;
  logic                  w_hit;
  logic                  w_mv;
  logic                  w_fv;
  logic [VOICE_W-1:0]    w_midx;
  logic [VOICE_W-1:0]    w_fidx;
  logic [VOICE_W-1:0]    w_oidx;
  logic [VOICE_W-1:0]    w_sel;
  logic [VOICE_W-1:0]    w_sel_age;
  logic                  w_last;
  logic                  w_go;
  assign busy        = r_state != S_IDLE;
  assign active_mask = r_active;
  assign w_ev        = note_pressed | note_released;
  // Scan trackers folded with the slot under inspection so the last slot is decided combinationally
  assign w_hit     = r_active[r_cnt] && r_snote[r_cnt] == r_note && r_sch[r_cnt] == r_ch;
  assign w_mv      = r_mv | w_hit;
  assign w_fv      = r_fv | ~r_active[r_cnt];
  assign w_midx    = r_mv ? r_midx : r_cnt;
  assign w_fidx    = r_fv ? r_fidx : r_cnt;
  assign w_oidx    = r_age[r_cnt] == LAST ? r_cnt : r_oidx;
  assign w_sel     = w_mv ? w_midx : w_fv ? w_fidx : w_oidx;
  assign w_sel_age = r_age[w_sel];
  assign w_last    = r_cnt == LAST;
  assign w_go      = r_on | w_mv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_note     <= '0;
      r_vel      <= '0;
      r_ch       <= '0;
      r_on       <= 1'b0;
      r_active   <= '0;
      r_mv       <= 1'b0;
      r_fv       <= 1'b0;
      r_midx     <= '0;
      r_fidx     <= '0;
      r_oidx     <= '0;
      voice_we   <= 1'b0;
      voice_idx  <= '0;
      voice_note <= '0;
      voice_vel  <= '0;
      voice_gate <= 1'b0;
      steal      <= 1'b0;
      drop       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_age[i]   <= VOICE_W'(i);
        r_snote[i] <= '0;
        r_sch[i]   <= '0;
      end
    end else begin
      voice_we <= 1'b0;
      steal    <= 1'b0;
      drop     <= w_ev & (busy | (note_pressed & note_released));
      if (r_state == S_IDLE && w_ev) begin
        r_state <= S_SCAN;
        r_cnt   <= '0;
        r_note  <= note;
        r_vel   <= velocity;
        r_ch    <= channel;
        r_on    <= note_pressed && velocity != 7'd0;
        r_mv    <= 1'b0;
        r_fv    <= 1'b0;
        r_oidx  <= '0;
      end else if (r_state == S_SCAN) begin
        r_cnt  <= r_cnt + 1'b1;
        r_mv   <= w_mv;
        r_fv   <= w_fv;
        r_midx <= w_midx;
        r_fidx <= w_fidx;
        r_oidx <= w_oidx;
        if (w_last) begin
          r_state <= w_go ? S_WRITE : S_IDLE;
          if (w_go) begin
            voice_we        <= 1'b1;
            voice_idx       <= w_sel;
            voice_note      <= r_note;
            voice_vel       <= r_vel;
            voice_gate      <= r_on;
            steal           <= r_on & ~w_mv & ~w_fv;
            r_active[w_sel] <= r_on;
            if (r_on) begin
              r_snote[w_sel] <= r_note;
              r_sch[w_sel]   <= r_ch;
              for (int i = 0; i < NUM_VOICES; i++)
                r_age[i] <= VOICE_W'(i) == w_sel ? '0 : r_age[i] < w_sel_age ? r_age[i] + 1'b1 : r_age[i];
            end
          end
        end
      end else if (r_state == S_WRITE) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench; stimulus queues expected writes/drops, a monitor checks them
module tb_voice_allocator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_pressed = 1'b0;
  logic       note_released = 1'b0;
  logic [6:0] note = '0;
  logic [6:0] velocity = '0;
  logic [3:0] channel = '0;
  logic       busy, voice_we, voice_gate, steal, drop;
  logic [2:0] voice_idx;
  logic [6:0] voice_note, voice_vel;
  logic [7:0] active_mask;
  typedef struct {
    int         t;
    logic [2:0] idx;
    logic [6:0] n;
    logic [6:0] v;
    logic       g;
    logic       s;
    logic [7:0] m;
  } exp_t;
  exp_t eq[$];
  int   dq[$];
  exp_t e;
  int   d;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  voice_allocator #(.NUM_VOICES(8), .VOICE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .note_pressed(note_pressed), .note_released(note_released),
    .note(note), .velocity(velocity), .channel(channel), .busy(busy), .voice_we(voice_we),
    .voice_idx(voice_idx), .voice_note(voice_note), .voice_vel(voice_vel),
    .voice_gate(voice_gate), .steal(steal), .drop(drop), .active_mask(active_mask)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (voice_we) begin
      if (eq.size() == 0) chk("unexpected_we", 32'(voice_we), 32'd0);
      else begin
        e = eq.pop_front();
        chk("we_time", cyc, e.t);
        chk("we_data", {voice_idx, voice_note, voice_vel, voice_gate, steal, active_mask},
                       {e.idx, e.n, e.v, e.g, e.s, e.m});
      end
    end else chk("steal_without_we", 32'(steal), 32'd0);
    if (drop) begin
      if (dq.size() == 0) chk("unexpected_drop", 32'(drop), 32'd0);
      else begin
        d = dq.pop_front();
        chk("drop_time", cyc, d);
      end
    end
  end
  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {busy, voice_we, voice_gate, steal, drop, voice_idx, voice_note, voice_vel}, 0);
    chk("reset_mask", 32'(active_mask), 0);
    rst_n = 1'b1;
  endtask
  task automatic pulse(input logic p, input logic r, input int n, input int v, input int c);
    note_pressed = p;
    note_released = r;
    note = 7'(n);
    velocity = 7'(v);
    channel = 4'(c);
    @(posedge clk);
    #1;
    note_pressed = 1'b0;
    note_released = 1'b0;
  endtask
  task automatic ev(input logic p, input logic r, input int n, input int v, input int c,
                    input logic we, input int idx, input logic g, input logic s, input int m);
    if (we) eq.push_back('{cyc + 9, 3'(idx), 7'(n), 7'(v), g, s, 8'(m)});
    pulse(p, r, n, v, c);
    repeat (9) @(posedge clk);
    #1;
  endtask
  initial begin
    reset_dut();
    ev(1, 0, 60, 100, 0, 1, 0, 1, 0, 8'h01);
    ev(1, 0, 64, 100, 0, 1, 1, 1, 0, 8'h03);
    ev(1, 0, 67, 100, 0, 1, 2, 1, 0, 8'h07);
    ev(0, 1, 64, 40, 0, 1, 1, 0, 0, 8'h05);
    pulse(0, 1, 70, 0, 0);
    repeat (7) @(posedge clk);
    #1 chk("nomatch_busy_scan", 32'(busy), 1);
    @(posedge clk);
    #1 chk("nomatch_busy_done", 32'(busy), 0);
    @(posedge clk);
    #1;
    reset_dut();
    for (int i = 0; i < 8; i++) ev(1, 0, 60 + i, 100, 0, 1, i, 1, 0, (1 << (i + 1)) - 1);
    ev(1, 0, 72, 90, 0, 1, 0, 1, 1, 8'hFF);
    ev(1, 0, 73, 90, 0, 1, 1, 1, 1, 8'hFF);
    reset_dut();
    ev(1, 0, 60, 100, 0, 1, 0, 1, 0, 8'h01);
    ev(1, 0, 60, 100, 1, 1, 1, 1, 0, 8'h03);
    ev(1, 0, 60, 0, 0, 1, 0, 0, 0, 8'h02);
    reset_dut();
    ev(1, 0, 60, 100, 0, 1, 0, 1, 0, 8'h01);
    ev(1, 0, 64, 100, 0, 1, 1, 1, 0, 8'h03);
    ev(1, 0, 67, 100, 0, 1, 2, 1, 0, 8'h07);
    ev(1, 0, 64, 50, 0, 1, 1, 1, 0, 8'h07);
    for (int i = 3; i < 8; i++) ev(1, 0, 65 + i, 100, 0, 1, i, 1, 0, (1 << (i + 1)) - 1);
    ev(1, 0, 80, 100, 0, 1, 0, 1, 1, 8'hFF);
    ev(1, 0, 81, 100, 0, 1, 2, 1, 1, 8'hFF);
    reset_dut();
    dq.push_back(cyc + 1);
    ev(1, 1, 50, 90, 0, 1, 0, 1, 0, 8'h01);
    eq.push_back('{cyc + 9, 3'd1, 7'd52, 7'd90, 1'b1, 1'b0, 8'h03});
    pulse(1, 0, 52, 90, 0);
    repeat (2) @(posedge clk);
    #1 dq.push_back(cyc + 1);
    pulse(1, 0, 70, 90, 0);
    repeat (6) @(posedge clk);
    #1;
    ev(1, 0, 53, 90, 0, 1, 2, 1, 0, 8'h07);
    pulse(1, 0, 54, 90, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midscan_reset", {busy, voice_we, active_mask}, 0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    ev(1, 0, 55, 90, 0, 1, 0, 1, 0, 8'h01);
    chk("we_queue_empty", eq.size(), 0);
    chk("drop_queue_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
